// File: rtl/seg_display_mux.sv
// seg_display_mux: scans four BCD digits onto a 4-digit common-anode
// seven-segment display. In adjust mode the selected digit pair blinks.
// Digit values 10-15 are shown as a dash so a runaway counter is visible.
module seg_display_mux #(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       adj,
   input  logic       sel,
   input  logic [3:0] sec_one,
   input  logic [3:0] sec_ten,
   input  logic [3:0] min_one,
   input  logic [3:0] min_ten,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       dp
);

   localparam int RW = $clog2(REFRESH_DIV);
   localparam int BW = $clog2(BLINK_DIV);
   localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

   logic [RW-1:0] rcnt;
   logic [1:0]    idx;
   logic [BW-1:0] bcnt;
   logic          blink_off;
   logic [3:0]    digit;
   logic          blank;
   logic [3:0]    an_nxt;
   logic [6:0]    seg_nxt;
   logic          dp_nxt;

   // Active-low segment patterns, bit 6 = g ... bit 0 = a.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      case (d)
         4'd0:    bcd_to_seg = 7'b1000000;
         4'd1:    bcd_to_seg = 7'b1111001;
         4'd2:    bcd_to_seg = 7'b0100100;
         4'd3:    bcd_to_seg = 7'b0110000;
         4'd4:    bcd_to_seg = 7'b0011001;
         4'd5:    bcd_to_seg = 7'b0010010;
         4'd6:    bcd_to_seg = 7'b0000010;
         4'd7:    bcd_to_seg = 7'b1111000;
         4'd8:    bcd_to_seg = 7'b0000000;
         4'd9:    bcd_to_seg = 7'b0010000;
         default: bcd_to_seg = 7'b0111111;
      endcase
   endfunction

   // Scan timing: dwell REFRESH_DIV cycles per slot, then step to the next digit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rcnt <= '0;
         idx  <= 2'd0;
      end else if (rcnt == R_LAST) begin
         rcnt <= '0;
         idx  <= idx + 2'd1;
      end else begin
         rcnt <= rcnt + RW'(1);
      end
   end

   // Blink phase: only runs in adjust mode, so each adj rise starts visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcnt      <= '0;
         blink_off <= 1'b0;
      end else if (!adj) begin
         bcnt      <= '0;
         blink_off <= 1'b0;
      end else if (bcnt == B_LAST) begin
         bcnt      <= '0;
         blink_off <= ~blink_off;
      end else begin
         bcnt <= bcnt + BW'(1);
      end
   end

   // Next pin values from the current slot; blanking overrides the whole slot.
   always_comb begin
      digit  = sec_one;
      an_nxt = 4'b1110;
      case (idx)
         2'd0: begin digit = sec_one; an_nxt = 4'b1110; end
         2'd1: begin digit = sec_ten; an_nxt = 4'b1101; end
         2'd2: begin digit = min_one; an_nxt = 4'b1011; end
         default: begin digit = min_ten; an_nxt = 4'b0111; end
      endcase
      // Slots 0,1 are the seconds pair (idx[1]=0), slots 2,3 the minutes pair.
      blank   = adj && blink_off && (sel ? !idx[1] : idx[1]);
      seg_nxt = bcd_to_seg(digit);
      dp_nxt  = (idx != 2'd2);
      if (blank) begin
         an_nxt  = 4'b1111;
         seg_nxt = 7'b1111111;
         dp_nxt  = 1'b1;
      end
   end

   // Registered pins, one cycle behind the slot index and inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an  <= 4'b1111;
         seg <= 7'b1111111;
         dp  <= 1'b1;
      end else begin
         an  <= an_nxt;
         seg <= seg_nxt;
         dp  <= dp_nxt;
      end
   end

endmodule

// File: tb/tb_seg_display_mux.sv
// Bench for seg_display_mux with REFRESH_DIV=4, BLINK_DIV=16.
`timescale 1ns/1ps
module tb_seg_display_mux;

   localparam int REFRESH_DIV = 4;
   localparam int BLINK_DIV   = 16;

   localparam logic [6:0] S0    = 7'b1000000;
   localparam logic [6:0] S1    = 7'b1111001;
   localparam logic [6:0] S2    = 7'b0100100;
   localparam logic [6:0] S3    = 7'b0110000;
   localparam logic [6:0] S4    = 7'b0011001;
   localparam logic [6:0] S5    = 7'b0010010;
   localparam logic [6:0] S6    = 7'b0000010;
   localparam logic [6:0] S7    = 7'b1111000;
   localparam logic [6:0] S8    = 7'b0000000;
   localparam logic [6:0] S9    = 7'b0010000;
   localparam logic [6:0] SDASH = 7'b0111111;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       adj = 1'b0;
   logic       sel = 1'b0;
   logic [3:0] sec_one = 4'd0;
   logic [3:0] sec_ten = 4'd0;
   logic [3:0] min_one = 4'd0;
   logic [3:0] min_ten = 4'd0;
   logic [6:0] seg;
   logic [3:0] an;
   logic       dp;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      string      name;
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      logic [3:0] mt, mo, st, so;
      logic [6:0] s0, s1, s2, s3;
   } vec_t;
   vec_t vecs[4];

   // Reference state: what the display should be doing right now.
   logic       m_adj;
   logic       m_sel;
   int         m_adj_start;
   logic [6:0] m_seg[4];

   seg_display_mux #(
      .REFRESH_DIV(REFRESH_DIV),
      .BLINK_DIV  (BLINK_DIV)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .adj    (adj),
      .sel    (sel),
      .sec_one(sec_one),
      .sec_ten(sec_ten),
      .min_one(min_one),
      .min_ten(min_ten),
      .seg    (seg),
      .an     (an),
      .dp     (dp)
   );

   always #5 clk = ~clk;

   task automatic compare(input string name, input logic [3:0] ea,
                          input logic [6:0] es, input logic ed);
      n_vec++;
      if ({an, seg, dp} !== {ea, es, ed}) begin
         n_bad++;
         $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                  name, an, seg, dp, ea, es, ed);
      end
   endtask

   task automatic check_reset(input string name);
      compare(name, 4'b1111, 7'b1111111, 1'b1);
   endtask

   // Push the expectation for output cycle k, clock once, pop and compare.
   task automatic expect_cycle(input string name, input int k);
      exp_t e;
      exp_t got;
      int   slot;
      logic blank;
      slot = ((k - 1) / REFRESH_DIV) % 4;
      e.name = $sformatf("%s k=%0d", name, k);
      case (slot)
         0: e.an = 4'b1110;
         1: e.an = 4'b1101;
         2: e.an = 4'b1011;
         default: e.an = 4'b0111;
      endcase
      e.seg = m_seg[slot];
      e.dp  = (slot == 2) ? 1'b0 : 1'b1;
      blank = m_adj && ((((k - m_adj_start) / BLINK_DIV) % 2) == 1) &&
              (m_sel ? (slot < 2) : (slot >= 2));
      if (blank) begin
         e.an  = 4'b1111;
         e.seg = 7'b1111111;
         e.dp  = 1'b1;
      end
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      compare(got.name, got.an, got.seg, got.dp);
   endtask

   task automatic start_run(input string name, input logic [3:0] mt, input logic [3:0] mo,
                            input logic [3:0] st, input logic [3:0] so,
                            input logic a, input logic s);
      rst = 1'b1;
      #1;
      check_reset({name, " reset"});
      min_ten = mt;
      min_one = mo;
      sec_ten = st;
      sec_one = so;
      adj     = a;
      sel     = s;
      m_adj   = a;
      m_sel   = s;
      m_adj_start = 1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{4'd1, 4'd2, 4'd3, 4'd4, S4, S3, S2, S1};
      vecs[1] = '{4'd5, 4'd6, 4'd7, 4'd8, S8, S7, S6, S5};
      vecs[2] = '{4'd9, 4'd0, 4'd10, 4'd15, SDASH, SDASH, S0, S9};
      vecs[3] = '{4'd12, 4'd11, 4'd13, 4'd14, SDASH, SDASH, SDASH, SDASH};

      #2;
      // Plain scan, adj=0: full 16-cycle rotation plus wrap into slot 0.
      foreach (vecs[i]) begin
         m_seg[0] = vecs[i].s0;
         m_seg[1] = vecs[i].s1;
         m_seg[2] = vecs[i].s2;
         m_seg[3] = vecs[i].s3;
         start_run($sformatf("vec%0d", i), vecs[i].mt, vecs[i].mo,
                   vecs[i].st, vecs[i].so, 1'b0, 1'b0);
         for (int k = 1; k <= 20; k++) expect_cycle($sformatf("vec%0d", i), k);
      end

      // Blink seconds pair: lit 1-16, blank 17-32, lit 33+.
      m_seg[0] = S9; m_seg[1] = S5; m_seg[2] = S0; m_seg[3] = S0;
      start_run("blink_sec", 4'd0, 4'd0, 4'd5, 4'd9, 1'b1, 1'b1);
      for (int k = 1; k <= 40; k++) expect_cycle("blink_sec", k);

      // Blink minutes pair, switch to seconds at cycle 20 mid-blank.
      start_run("sel_sw", 4'd0, 4'd0, 4'd5, 4'd9, 1'b1, 1'b0);
      for (int k = 1; k <= 19; k++) expect_cycle("sel_sw", k);
      sel = 1'b1;
      m_sel = 1'b1;
      for (int k = 20; k <= 40; k++) expect_cycle("sel_sw", k);

      // Drop adj while blanked, then re-assert: visible phase comes first.
      start_run("adj_drop", 4'd0, 4'd0, 4'd5, 4'd9, 1'b1, 1'b1);
      for (int k = 1; k <= 20; k++) expect_cycle("adj_drop", k);
      adj = 1'b0;
      m_adj = 1'b0;
      for (int k = 21; k <= 24; k++) expect_cycle("adj_drop", k);
      adj = 1'b1;
      m_adj = 1'b1;
      m_adj_start = 25;
      for (int k = 25; k <= 56; k++) expect_cycle("adj_drop", k);

      // Mid-slot input change, then asynchronous reset during slot 2.
      m_seg[0] = S4; m_seg[1] = S3; m_seg[2] = S2; m_seg[3] = S1;
      start_run("async", 4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0);
      for (int k = 1; k <= 2; k++) expect_cycle("async", k);
      sec_one  = 4'd10;
      m_seg[0] = SDASH;
      for (int k = 3; k <= 10; k++) expect_cycle("async", k);
      #2;
      rst = 1'b1;
      #1;
      check_reset("async mid-slot reset");
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) expect_cycle("async restart", k);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
